// File: rtl/rtlola_pkg.sv
// Shared types and constants for the RTLola input-event front end.
package rtlola_pkg;

    // Default configuration of the monitor's input entity.
    localparam int NUM_IN_DEF = 2;
    localparam int DATA_W_DEF = 64;
    localparam int TAG_W_DEF  = 64;

    // Width of the saturating dropped-event counter.
    localparam int DROP_W = 16;

    // One queued event in the default configuration: lane values, new-value mask, timestamp.
    typedef struct packed {
        logic [NUM_IN_DEF*DATA_W_DEF-1:0] lanes;
        logic [NUM_IN_DEF-1:0]            new_mask;
        logic [TAG_W_DEF-1:0]             tag;
    } entry_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rtlola_fifo_fwft.sv
// Generic first-word-fall-through queue: the head entry is on rd_data whenever
// empty is low. Occupancy is tracked by an explicit counter so DEPTH need not be
// a power of two.
module rtlola_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A pop on an empty queue is ignored; a pop frees a slot for a same-edge push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Gate the head with empty so the outputs read zero after reset and when drained.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage write port.
    // NOTE: the storage array carries no reset; validity comes from count, and
    // resetting every word would only add a wide reset fan-out for no benefit.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy, wrapping at DEPTH-1.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rtlola_event_queue.sv
// Input-event front end: samples NUM_IN streams, fills absent lanes from
// per-lane hold registers, stamps each event with a cycle tag and queues it for
// the evaluator. Events arriving at a full queue without a pop are dropped and
// counted.
module rtlola_event_queue
    import rtlola_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_IN*DATA_W-1:0]   in_data,
    input  logic [NUM_IN-1:0]          in_new,
    input  logic                       pop,
    output logic [NUM_IN*DATA_W-1:0]   out_data,
    output logic [NUM_IN-1:0]          out_new,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int LANES_W = NUM_IN * DATA_W;

    // Entry layout for this instance's parameters.
    typedef struct packed {
        logic [LANES_W-1:0] lanes;
        logic [NUM_IN-1:0]  new_mask;
        logic [TAG_W-1:0]   tag;
    } q_entry_t;

    localparam int ENTRY_W = $bits(q_entry_t);

    logic [TAG_W-1:0]   tag_q;
    logic [LANES_W-1:0] hold_q;
    logic [LANES_W-1:0] lanes_mux;
    logic               push_req;
    logic               pop_req;
    logic               fifo_full;
    logic               fifo_empty;
    logic               drop;
    q_entry_t           wr_entry;
    q_entry_t           rd_entry;
    logic [ENTRY_W-1:0] rd_flat;

    assign push_req = en & (|in_new);
    assign pop_req  = en & pop;
    // When full the queue is non-empty, so a pop always makes room.
    assign drop     = push_req & fifo_full & ~pop_req;

    // Lane selection: fresh value where flagged, otherwise last held value.
    // NOTE: the default assignment first keeps every bit driven on every path,
    // so no latch is inferred for lanes whose flag is low.
    always_comb begin
        lanes_mux = hold_q;
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_new[i]) lanes_mux[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
        end
    end

    assign wr_entry = '{lanes: lanes_mux, new_mask: in_new, tag: tag_q};

    rtlola_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_req),
        .pop     (pop_req),
        .wr_data (wr_entry),
        .rd_data (rd_flat),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign rd_entry  = q_entry_t'(rd_flat);
    assign out_data  = rd_entry.lanes;
    assign out_new   = rd_entry.new_mask;
    assign out_tag   = rd_entry.tag;
    assign out_valid = ~fifo_empty;
    assign full      = fifo_full;

    // Free-running cycle tag; an event carries the value before this edge's increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    tag_q <= '0;
        else if (en) tag_q <= tag_q + 1'b1;
    end

    // Hold registers capture every flagged value, including ones that get dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
        end else if (en) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (in_new[i]) hold_q[i*DATA_W +: DATA_W] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

endmodule

// File: tb/tb_rtlola_event_queue.sv
// Directed bench for rtlola_event_queue with NUM_IN=2, DATA_W=64, DEPTH=4, TAG_W=64.
module tb_rtlola_event_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [127:0] in_data;
    logic [1:0]   in_new;
    logic         pop;
    logic [127:0] out_data;
    logic [1:0]   out_new;
    logic [63:0]  out_tag;
    logic         out_valid;
    logic         full;
    logic [2:0]   count;
    logic         overflow;
    logic [15:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    rtlola_event_queue #(
        .NUM_IN (2),
        .DATA_W (64),
        .DEPTH  (4),
        .TAG_W  (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_data   (in_data),
        .in_new    (in_new),
        .pop       (pop),
        .out_data  (out_data),
        .out_new   (out_new),
        .out_tag   (out_tag),
        .out_valid (out_valid),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Packs {lane1, lane0}.
    function automatic logic [127:0] lanes(input logic [63:0] l0, input logic [63:0] l1);
        return {l1, l0};
    endfunction

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [127:0] d, input logic [1:0] nw,
                        input logic [63:0] t, input logic [2:0] c);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"},  out_data, d);
        check({tag, "_new"},   out_new, nw);
        check({tag, "_tag"},   out_tag, t);
        check({tag, "_count"}, count, c);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; in_data = '0; in_new = 2'b00; pop = 1'b0;
        #12;
        check("rst_valid", out_valid, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_full",  full, 1'b0);
        check("rst_ovf",   overflow, 1'b0);
        check("rst_drop",  drop_cnt, 16'd0);
        check("rst_data",  out_data, 128'd0);
        check("rst_tag",   out_tag, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Two pushes at tags 0 and 2, nothing at tag 1.
        en = 1'b1;
        in_new = 2'b11; in_data = lanes(1, 1); step();
        in_new = 2'b00; step();
        in_new = 2'b11; in_data = lanes(2, 2); step();
        in_new = 2'b00;
        head("two_push", lanes(1, 1), 2'b11, 64'd0, 3'd2);
        pop = 1'b1; step();                       // tag 3
        head("pop1", lanes(2, 2), 2'b11, 64'd2, 3'd1);
        step();                                   // tag 4, drains
        check("drain_valid", out_valid, 1'b0);
        check("drain_data",  out_data, 128'd0);
        pop = 1'b0;

        // Sample-and-hold: lane1 held at 2, then lane0 held at 5.
        in_new = 2'b01; in_data = lanes(5, 99);  step();   // tag 5
        in_new = 2'b10; in_data = lanes(123, 7); step();   // tag 6
        in_new = 2'b00;
        head("hold_a", lanes(5, 2), 2'b01, 64'd5, 3'd2);
        pop = 1'b1; step();                                // tag 7
        head("hold_b", lanes(5, 7), 2'b10, 64'd6, 3'd1);
        step();                                            // tag 8
        pop = 1'b0;
        check("hold_empty", count, 3'd0);

        // Fill to DEPTH at tags 9..12.
        in_new = 2'b11;
        for (int k = 10; k <= 13; k++) begin
            in_data = lanes(64'(k), 64'(k)); step();
        end
        check("fill_full", full, 1'b1);
        check("fill_ovf",  overflow, 1'b0);
        head("fill", lanes(10, 10), 2'b11, 64'd9, 3'd4);

        // Full with push and pop together: no drop.
        in_data = lanes(20, 20); pop = 1'b1; step();       // tag 13
        check("pp_ovf",  overflow, 1'b0);
        check("pp_drop", drop_cnt, 16'd0);
        head("pp", lanes(11, 11), 2'b11, 64'd10, 3'd4);

        // Full without pop: dropped, hold still updates to 14.
        in_data = lanes(14, 14); pop = 1'b0; step();       // tag 14
        check("ovf_flag", overflow, 1'b1);
        check("ovf_drop", drop_cnt, 16'd1);
        check("ovf_full", full, 1'b1);
        head("ovf", lanes(11, 11), 2'b11, 64'd10, 3'd4);

        // Drain three to reach the entry added by push+pop at the tail.
        in_new = 2'b00; pop = 1'b1;
        step(); step(); step();                            // tags 15..17
        head("tail", lanes(20, 20), 2'b11, 64'd13, 3'd1);
        check("tail_ovf_sticky", overflow, 1'b1);

        // Enable low: everything frozen.
        en = 1'b0; in_new = 2'b11; in_data = lanes(50, 50);
        step(); step(); step();
        head("frozen", lanes(20, 20), 2'b11, 64'd13, 3'd1);

        // Resume: tag continues at 18, lane1 holds the dropped value 14.
        en = 1'b1; pop = 1'b0; in_new = 2'b01; in_data = lanes(30, 77); step();
        check("resume_count", count, 3'd2);
        in_new = 2'b00; pop = 1'b1; step();                // tag 19
        head("resume", lanes(30, 14), 2'b01, 64'd18, 3'd1);

        // Reach count=3 then reset asynchronously mid-cycle.
        pop = 1'b0; in_new = 2'b11;
        in_data = lanes(40, 40); step();
        in_data = lanes(41, 41); step();
        check("pre_rst_count", count, 3'd3);
        in_new = 2'b00;
        #2 rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_count", count, 3'd0);
        check("arst_ovf",   overflow, 1'b0);
        check("arst_drop",  drop_cnt, 16'd0);
        check("arst_data",  out_data, 128'd0);
        check("arst_tag",   out_tag, 64'd0);
        check("arst_new",   out_new, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;

        // First push after reset tags 0 and sees cleared hold registers.
        in_new = 2'b01; in_data = lanes(9, 88); step();
        in_new = 2'b00;
        head("post_rst", lanes(9, 0), 2'b01, 64'd0, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
